// File: rtl/lemming_pkg.sv
// rtl/lemming_pkg.sv - shared types and width helpers for the lemming bridge arbiter
package lemming_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CROSS = 2'd1,
        GAP   = 2'd2
    } lemming_state_e;

    localparam int N_DEF     = 4;
    localparam int CROSS_DEF = 5;
    localparam int GAP_DEF   = 1;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Counters only ever hold max-1, so clog2(max) bits suffice.
    function automatic int cnt_w(input int cross_cycles, input int gap_cycles);
        int m;
        m = (cross_cycles > gap_cycles) ? cross_cycles : gap_cycles;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

    localparam int ID_W = id_w(N_DEF);

endpackage

// File: rtl/lemming_bridge_arbiter_if.sv
// rtl/lemming_bridge_arbiter_if.sv - request/grant bundle between walkers and the bridge arbiter
interface lemming_bridge_arbiter_if import lemming_pkg::*; #(
    parameter int N = 4
);
    localparam int IW = id_w(N);

    logic [N-1:0]  req;
    logic [N-1:0]  ground;
    logic [N-1:0]  grant;
    logic          busy;
    logic [IW-1:0] owner;
    logic          done;
    logic          abort;

    modport master (
        input  req, ground,
        output grant, busy, owner, done, abort
    );

    modport slave (
        output req, ground,
        input  grant, busy, owner, done, abort
    );

endinterface

// File: rtl/lemming_rr_pick.sv
// rtl/lemming_rr_pick.sv - wrap-around priority search starting at ptr
module lemming_rr_pick import lemming_pkg::*; #(
    parameter int N = 4
) (
    input  logic [N-1:0]       eligible_i,
    input  logic [id_w(N)-1:0] ptr_i,
    output logic               valid_o,
    output logic [id_w(N)-1:0] idx_o
);
    localparam int IW = id_w(N);

    // Scan from the farthest offset down so the nearest eligible index wins.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            int j;
            j = int'(ptr_i) + i;
            if (j >= N) j = j - N;
            if (eligible_i[j]) begin
                valid_o = 1'b1;
                idx_o   = IW'(j);
            end
        end
    end

endmodule

// File: rtl/lemming_bridge_arbiter.sv
// rtl/lemming_bridge_arbiter.sv - round-robin owner of the one-lane bridge with crossing timer and gap
module lemming_bridge_arbiter import lemming_pkg::*; #(
    parameter int N            = 4,
    parameter int CROSS_CYCLES = 5,
    parameter int GAP_CYCLES   = 1
) (
    input  logic                       clk,
    input  logic                       resetn,
    lemming_bridge_arbiter_if.master   bus
);
    localparam int IW = id_w(N);
    localparam int CW = cnt_w(CROSS_CYCLES, GAP_CYCLES);

    localparam logic [N-1:0]   ONE        = N'(1);
    localparam logic [CW-1:0]  CROSS_LOAD = CW'(CROSS_CYCLES - 1);
    localparam logic [CW-1:0]  GAP_LOAD   = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;
    localparam lemming_state_e LEAVE_ST   = (GAP_CYCLES > 0) ? GAP : IDLE;
    localparam logic           LEAVE_BUSY = (GAP_CYCLES > 0);

    lemming_state_e state_q;
    logic [N-1:0]   grant_q;
    logic [IW-1:0]  owner_q;
    logic [IW-1:0]  ptr_q;
    logic [CW-1:0]  cnt_q;
    logic           busy_q;
    logic           done_q;
    logic           abort_q;

    logic [N-1:0]   eligible;
    logic           pick_valid;
    logic [IW-1:0]  pick_idx;
    logic           owner_ok;
    logic [IW-1:0]  ptr_next;

    assign eligible = bus.req & bus.ground;
    assign owner_ok = bus.req[owner_q] & bus.ground[owner_q];
    assign ptr_next = (int'(owner_q) == N - 1) ? '0 : owner_q + IW'(1);

    lemming_rr_pick #(.N(N)) u_pick (
        .eligible_i (eligible),
        .ptr_i      (ptr_q),
        .valid_o    (pick_valid),
        .idx_o      (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        state_q <= CROSS;
                        grant_q <= ONE << pick_idx;
                        owner_q <= pick_idx;
                        cnt_q   <= CROSS_LOAD;
                        busy_q  <= 1'b1;
                    end
                end
                CROSS: begin
                    // A fall or withdrawal outranks a crossing that would finish this edge.
                    if (!owner_ok || cnt_q == '0) begin
                        state_q <= LEAVE_ST;
                        grant_q <= '0;
                        ptr_q   <= ptr_next;
                        cnt_q   <= GAP_LOAD;
                        busy_q  <= LEAVE_BUSY;
                        abort_q <= !owner_ok;
                        done_q  <= owner_ok;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                GAP: begin
                    if (cnt_q == '0) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.grant = grant_q;
    assign bus.busy  = busy_q;
    assign bus.owner = owner_q;
    assign bus.done  = done_q;
    assign bus.abort = abort_q;

endmodule

// File: tb/tb_lemming_bridge_arbiter.sv
// tb/tb_lemming_bridge_arbiter.sv - directed self-checking bench for the lemming bridge arbiter
module tb_lemming_bridge_arbiter;

    logic clk;
    logic resetn;
    int   n_pass;
    int   n_total;

    lemming_bridge_arbiter_if #(.N(4)) bus ();

    lemming_bridge_arbiter #(
        .N            (4),
        .CROSS_CYCLES (5),
        .GAP_CYCLES   (1)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        bus.req = 4'b0000;
        bus.ground = 4'b1111;
        tick();
        resetn = 1'b1;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (bus.busy && k < 20) begin
            tick();
            k++;
        end
        n_total++;
        if (bus.busy !== 1'b0) $display("FAIL wait_idle: busy=%b required 0 after %0d cycles", bus.busy, k);
        else n_pass++;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        bus.req = 4'b1111;
        bus.ground = 4'b1111;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_total++;
            if (bus.grant !== 4'b0000) $display("FAIL reset_grant: got %b required 0000", bus.grant);
            else n_pass++;
            n_total++;
            if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b required 0", bus.busy);
            else n_pass++;
            n_total++;
            if (bus.done !== 1'b0 || bus.abort !== 1'b0)
                $display("FAIL reset_pulses: done=%b abort=%b required 0 0", bus.done, bus.abort);
            else n_pass++;
            n_total++;
            if (bus.owner !== 2'd0) $display("FAIL reset_owner: got %0d required 0", bus.owner);
            else n_pass++;
        end
        resetn = 1'b1;
        tick();
        n_total++;
        if (bus.grant !== 4'b0001) $display("FAIL reset_first_grant: got %b required 0001", bus.grant);
        else n_pass++;
        bus.req = 4'b0000;
        wait_idle();
    endtask

    task automatic test_single();
        logic [3:0] e_grant;
        do_reset();
        bus.req = 4'b0100;
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (c == 7) bus.req = 4'b0000;
            e_grant = (c <= 5) ? 4'b0100 : 4'b0000;
            n_total++;
            if (bus.grant !== e_grant) $display("FAIL single_grant c%0d: got %b required %b", c, bus.grant, e_grant);
            else n_pass++;
            n_total++;
            if (bus.done !== (c == 6)) $display("FAIL single_done c%0d: got %b required %b", c, bus.done, (c == 6));
            else n_pass++;
            n_total++;
            if (bus.busy !== (c <= 6)) $display("FAIL single_busy c%0d: got %b required %b", c, bus.busy, (c <= 6));
            else n_pass++;
            n_total++;
            if (bus.abort !== 1'b0) $display("FAIL single_abort c%0d: got %b required 0", c, bus.abort);
            else n_pass++;
        end
        n_total++;
        if (bus.owner !== 2'd2) $display("FAIL single_owner: got %0d required 2", bus.owner);
        else n_pass++;
    endtask

    task automatic test_fairness();
        logic [3:0] e_grant;
        int slot;
        int pos;
        do_reset();
        bus.req = 4'b1111;
        for (int c = 1; c <= 30; c++) begin
            tick();
            slot = (c - 1) / 7;
            pos = (c - 1) % 7;
            e_grant = (pos < 5) ? (4'b0001 << (slot % 4)) : 4'b0000;
            n_total++;
            if (bus.grant !== e_grant) $display("FAIL fair_grant c%0d: got %b required %b", c, bus.grant, e_grant);
            else n_pass++;
        end
        bus.req = 4'b0000;
        wait_idle();
    endtask

    task automatic test_ineligible();
        do_reset();
        bus.req = 4'b0010;
        bus.ground = 4'b1101;
        for (int c = 1; c <= 4; c++) begin
            tick();
            n_total++;
            if (bus.grant !== 4'b0000 || bus.busy !== 1'b0)
                $display("FAIL inelig_idle c%0d: grant=%b busy=%b required 0000 0", c, bus.grant, bus.busy);
            else n_pass++;
        end
        bus.ground = 4'b1111;
        tick();
        n_total++;
        if (bus.grant !== 4'b0010) $display("FAIL inelig_grant: got %b required 0010", bus.grant);
        else n_pass++;
        bus.req = 4'b0000;
        wait_idle();
    endtask

    task automatic test_abort();
        do_reset();
        bus.req = 4'b1000;
        for (int c = 1; c <= 3; c++) begin
            tick();
            n_total++;
            if (bus.grant !== 4'b1000) $display("FAIL abort_pre_grant c%0d: got %b required 1000", c, bus.grant);
            else n_pass++;
        end
        bus.ground = 4'b0111;
        bus.req = 4'b1001;
        tick();
        bus.ground = 4'b1111;
        n_total++;
        if (bus.grant !== 4'b0000 || bus.abort !== 1'b1 || bus.done !== 1'b0)
            $display("FAIL abort_pulse: grant=%b abort=%b done=%b required 0000 1 0", bus.grant, bus.abort, bus.done);
        else n_pass++;
        tick();
        n_total++;
        if (bus.abort !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b0)
            $display("FAIL abort_after: abort=%b done=%b busy=%b required 0 0 0", bus.abort, bus.done, bus.busy);
        else n_pass++;
        tick();
        n_total++;
        if (bus.grant !== 4'b0001) $display("FAIL abort_next_grant: got %b required 0001", bus.grant);
        else n_pass++;
        bus.req = 4'b0000;
        wait_idle();
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.req = 4'b0100;
        tick();
        n_total++;
        if (bus.grant !== 4'b0100) $display("FAIL rmid_grant: got %b required 0100", bus.grant);
        else n_pass++;
        tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        bus.req = 4'b1111;
        n_total++;
        if (bus.grant !== 4'b0000 || bus.busy !== 1'b0 || bus.owner !== 2'd0)
            $display("FAIL rmid_state: grant=%b busy=%b owner=%0d required 0000 0 0", bus.grant, bus.busy, bus.owner);
        else n_pass++;
        n_total++;
        if (bus.done !== 1'b0 || bus.abort !== 1'b0)
            $display("FAIL rmid_pulses: done=%b abort=%b required 0 0", bus.done, bus.abort);
        else n_pass++;
        tick();
        n_total++;
        if (bus.grant !== 4'b0001 || bus.done !== 1'b0 || bus.abort !== 1'b0)
            $display("FAIL rmid_ptr: grant=%b done=%b abort=%b required 0001 0 0", bus.grant, bus.done, bus.abort);
        else n_pass++;
        bus.req = 4'b0000;
        wait_idle();
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        resetn = 1'b0;
        bus.req = 4'b0000;
        bus.ground = 4'b1111;
        test_reset();
        test_single();
        test_fairness();
        test_ineligible();
        test_abort();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/lemming_bridge_arbiter.md
Name: lemming_bridge_arbiter

Overview:
Round-robin arbiter that shares a single one-lane bridge between N lemming walkers.
- Each walker requests to cross; the arbiter grants at most one at a time.
- It times the crossing, aborts if the owner falls or withdraws, and enforces a gap before the next grant.
- It sits between the per-lemming walk/fall FSMs and the bridge resource; per-lemming `ground` comes from those FSMs' environment.

Parameters:
- N, 4, number of requesters (N >= 2).
- CROSS_CYCLES, 5, grant duration for a successful crossing (>= 1).
- GAP_CYCLES, 1, idle cycles after a crossing before re-arbitration (0 allowed = no gap state).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- resetn  in  1  synchronous active-low reset, sampled on rising clk.
- req  in  N  level request per lemming; must be held until granted.
- ground  in  N  per-lemming ground flag; a requester is eligible only while ground[i]=1.
- grant  out  N  one-hot (or zero) bridge ownership, registered.
- busy  out  1  high whenever state != IDLE.
- owner  out  $clog2(N)  index of current/last grantee; held through GAP.
- done  out  1  one-cycle pulse: crossing completed.
- abort  out  1  one-cycle pulse: crossing aborted.

Behaviour:
- Reset (resetn=0 at an edge): state=IDLE, grant=0, busy=0, owner=0, done=0, abort=0, rr pointer ptr=0, counters=0. Reset has priority over everything, including mid-crossing. No done/abort pulse results from a reset.
- States: IDLE, CROSS, GAP; all outputs are registered.
- IDLE:
  - eligible = req & ground.
  - If eligible != 0, pick the first set bit at index >= ptr, wrapping modulo N.
  - Next edge: state=CROSS, grant[w]=1, owner=w, cnt=CROSS_CYCLES-1.
  - Latency: eligible at edge k gives grant visible after edge k+1.
- CROSS, evaluated each edge:
  - (a) If req[owner]=0 or ground[owner]=0: grant=0, abort=1 for one cycle, ptr=(owner+1)%N, leave CROSS.
  - (b) Else if cnt==0: grant=0, done=1 for one cycle, ptr=(owner+1)%N, leave CROSS.
  - (c) Else cnt=cnt-1.
  - Abort has priority over done in the same cycle.
  - A successful crossing holds grant for exactly CROSS_CYCLES cycles; done coincides with the first cycle grant is low.
- Leaving CROSS: go to GAP with gcnt=GAP_CYCLES-1 if GAP_CYCLES>0, else straight to IDLE.
- GAP: busy=1, grant=0. When gcnt==0 go to IDLE, else gcnt=gcnt-1.
- Requests arriving during CROSS/GAP are not latched; only the levels sampled in IDLE matter.
- Requester i with req[i]=1 but ground[i]=0 is skipped, and ptr is unchanged by the skip.
- grant is never multi-hot; busy=0 implies grant=0.

Decomposition:
- Package lemming_pkg holds:
  - state enum {IDLE, CROSS, GAP};
  - localparam ID_W=$clog2(N) helper;
  - counter width helper sized for max(CROSS_CYCLES, GAP_CYCLES).
- One combinational sub-module: lemming_rr_pick (inputs: eligible, ptr; outputs: valid, idx). It is a wrap-around priority search, reusable for other shared lemming resources.

Test Plan:
All scenarios use N=4, CROSS_CYCLES=5, GAP_CYCLES=1, ground=4'b1111 unless stated.
- Reset: resetn=0 for 2 cycles with req=4'b1111 -> grant=0, busy=0, done=0, abort=0, owner=0 throughout; first grant after release is 4'b0001.
- Single crossing: req=4'b0100 from cycle 0 ->
  - grant=4'b0100 during cycles 1-5;
  - done=1 only in cycle 6, owner=2;
  - busy=1 during cycles 1-6, busy=0 in cycle 7.
- Fairness: req=4'b1111 held -> grants in order 0001, 0010, 0100, 1000, 0001, each starting 7 cycles apart (cycles 1, 8, 15, 22, 29).
- Ineligible: req=4'b0010, ground=4'b1101 for 4 cycles -> grant stays 0. When ground[1] rises at cycle 4, grant=4'b0010 at cycle 5.
- Abort: owner=3 crossing; ground[3]=0 during the 3rd grant cycle ->
  - next cycle grant=0, abort=1 (one cycle), done stays 0;
  - with req=4'b1001 the next grant goes to index 0.
- Reset mid-crossing: resetn=0 during the 2nd grant cycle -> next cycle grant=0, busy=0, no done/abort pulse, ptr=0.
